// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_pkg;

    // Mult/div occupancy FSM states
    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Register $zero never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default EX-stage latency of a mult/div instruction
    localparam int MD_LAT_DEFAULT = 4;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and per-stage pipeline controls between the datapath and
// the stall/flush sequencer. The slave side is the sequencer.
interface pipe_stall_ctrl_if;

    // hazard sources
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_uses_rt;
    logic       ex_branch_taken;
    logic       ex_md_start;
    logic       dmem_req;
    logic       dmem_ready;

    // pipeline register controls
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_bubble;
    logic       ex_mem_write;
    logic       ex_mem_bubble;
    logic       mem_wb_bubble;
    logic       md_busy;

    modport master (
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               ex_branch_taken, ex_md_start, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, ex_mem_bubble, mem_wb_bubble, md_busy
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               ex_branch_taken, ex_md_start, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, ex_mem_bubble, mem_wb_bubble, md_busy
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read
// by the instruction in ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       if_id_uses_rt,
    output logic       load_use
);

    assign load_use = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && (id_ex_rt == if_id_rt)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core. Merges memory wait,
// mult/div occupancy, taken-branch flush and load-use into per-stage
// controls by strict priority. Optional macro STALL_PERF_EN adds stall and
// flush performance counters.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int CNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_stall_ctrl_if.slave   bus
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_cnt
`endif
);

    // A single-cycle mult/div never needs to hold EX
    localparam bit             MD_MULTI = (MD_LAT > 1);
    localparam logic [CNT_W-1:0] MD_LOAD = MD_MULTI ? CNT_W'(MD_LAT - 2) : '0;

    md_state_t        state;
    logic [CNT_W-1:0] md_cnt;

    logic mem_stall;
    logic md_stall;
    logic load_use;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic ex_mem_bubble;
    logic mem_wb_bubble;

    hazard_detect u_hazard_detect (
        .id_ex_mem_read (bus.id_ex_mem_read),
        .id_ex_rt       (bus.id_ex_rt),
        .if_id_rs       (bus.if_id_rs),
        .if_id_rt       (bus.if_id_rt),
        .if_id_uses_rt  (bus.if_id_uses_rt),
        .load_use       (load_use)
    );

    assign mem_stall = bus.dmem_req && !bus.dmem_ready;
    // The first mult/div cycle stalls from IDLE; the last cycle (md_cnt==0)
    // is the release cycle where EX advances.
    assign md_stall  = ((state == IDLE) && bus.ex_md_start && MD_MULTI) ||
                       ((state == MD_BUSY) && (md_cnt != '0));

    // Priority resolution: only the highest active hazard drives the controls
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        if (mem_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (md_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
            // A branch frozen behind a stall stays asserted, so its flush
            // lands in the first unfrozen cycle. It also squashes any
            // load-use victim sitting in ID.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Mult/div occupancy FSM and countdown; the counter keeps running
    // through memory stalls so latency overlaps with the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ex_md_start && !mem_stall && MD_MULTI) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt != '0) begin
                        md_cnt <= md_cnt - CNT_W'(1);
                    end
                    if ((md_cnt == '0) && !mem_stall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.if_id_write   = if_id_write;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_write   = id_ex_write;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.ex_mem_write  = ex_mem_write;
    assign bus.ex_mem_bubble = ex_mem_bubble;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.md_busy       = (state == MD_BUSY);

`ifdef STALL_PERF_EN
    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_cnt    <= '0;
        end else begin
            if (!pc_write) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (if_id_flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl (MD_LAT=4). Stimulus pushes the
// hand-computed control vector per cycle; a negedge monitor pops and checks.
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst_n;

    pipe_stall_ctrl_if bus ();

`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_stall_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef STALL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
    //  ex_mem_write, ex_mem_bubble, mem_wb_bubble, md_busy}
    localparam logic [8:0] V_DEF = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] V_MEM = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] V_MD  = 9'b0_0_0_0_0_1_1_0_0;
    localparam logic [8:0] V_BR  = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] V_LU  = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] BUSY  = 9'b0_0_0_0_0_0_0_0_1;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks = 0;
    int errors = 0;

    logic [8:0] act_vec;
    assign act_vec = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                      bus.id_ex_write, bus.id_ex_bubble, bus.ex_mem_write,
                      bus.ex_mem_bubble, bus.mem_wb_bubble, bus.md_busy};

    // Monitor: one comparison per presented cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            checks++;
            if (act_vec !== it.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", it.name, act_vec, it.exp);
            end else begin
                $display("ok   %s: %b", it.name, act_vec);
            end
        end
    end

    // Drive one cycle of inputs just after the edge and queue its expectation
    task automatic step(input string name, input logic rst,
                        input logic rd, input logic [4:0] ex_rt,
                        input logic [4:0] rs, input logic [4:0] id_rt,
                        input logic uses, input logic br, input logic md,
                        input logic req, input logic rdy,
                        input logic [8:0] exp);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst_n                = rst;
        bus.id_ex_mem_read   = rd;
        bus.id_ex_rt         = ex_rt;
        bus.if_id_rs         = rs;
        bus.if_id_rt         = id_rt;
        bus.if_id_uses_rt    = uses;
        bus.ex_branch_taken  = br;
        bus.ex_md_start      = md;
        bus.dmem_req         = req;
        bus.dmem_ready       = rdy;
        it.name = name;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic idle(input string name, input logic [8:0] exp);
        step(name, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic md(input string name, input logic req, input logic rdy,
                      input logic [8:0] exp);
        step(name, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, req, rdy, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.id_ex_mem_read  = 1'b0;
        bus.id_ex_rt        = 5'd0;
        bus.if_id_rs        = 5'd0;
        bus.if_id_rt        = 5'd0;
        bus.if_id_uses_rt   = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.ex_md_start     = 1'b0;
        bus.dmem_req        = 1'b0;
        bus.dmem_ready      = 1'b0;

        // reset state
        step("reset", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF);
        idle("idle", V_DEF);

        // load-use
        step("lu_rs",     1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_LU);
        step("lu_zero",   1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF);
        step("lu_rt_nouse", 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF);
        step("lu_rt_use", 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU);
        step("lu_noload", 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF);

        // mult/div, MD_LAT=4
        md("md_c1", 1'b0, 1'b0, V_MD);
        md("md_c2", 1'b0, 1'b0, V_MD | BUSY);
        md("md_c3", 1'b0, 1'b0, V_MD | BUSY);
        md("md_c4_release", 1'b0, 1'b0, V_DEF | BUSY);
        idle("md_after", V_DEF);

        // memory wait overlapping a mult/div
        md("mdm_c1", 1'b0, 1'b0, V_MD);
        md("mdm_w1", 1'b1, 1'b0, V_MEM | BUSY);
        md("mdm_w2", 1'b1, 1'b0, V_MEM | BUSY);
        md("mdm_w3", 1'b1, 1'b0, V_MEM | BUSY);
        md("mdm_w4", 1'b1, 1'b0, V_MEM | BUSY);
        md("mdm_w5", 1'b1, 1'b0, V_MEM | BUSY);
        md("mdm_release", 1'b1, 1'b1, V_DEF | BUSY);
        idle("mdm_after", V_DEF);

        // branch beats load-use
        step("br_vs_lu", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BR);

        // branch frozen by a memory wait
        step("brf_c1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, V_MEM);
        step("brf_c2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, V_MEM);
        step("brf_c3", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BR);
        idle("brf_after", V_DEF);

        // mult/div arriving during a memory wait starts only once unfrozen
        md("mdd_wait", 1'b1, 1'b0, V_MEM);
        md("mdd_c1", 1'b0, 1'b0, V_MD);
        md("mdd_c2", 1'b0, 1'b0, V_MD | BUSY);
        md("mdd_c3", 1'b0, 1'b0, V_MD | BUSY);
        md("mdd_c4", 1'b0, 1'b0, V_DEF | BUSY);
        idle("mdd_after", V_DEF);

        // reset while md_cnt==2, then a full restart
        md("mdr_c1", 1'b0, 1'b0, V_MD);
        step("mdr_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF);
`ifdef STALL_PERF_EN
        #1;
        checks++;
        if (perf_stall_cycles !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got stall=%0d flush=%0d expected 0 0",
                     perf_stall_cycles, perf_flush_cnt);
        end else begin
            $display("ok   perf_reset: 0 0");
        end
`endif
        step("mdr_hold", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF);
        md("mdr2_c1", 1'b0, 1'b0, V_MD);
        md("mdr2_c2", 1'b0, 1'b0, V_MD | BUSY);
        md("mdr2_c3", 1'b0, 1'b0, V_MD | BUSY);
        md("mdr2_c4", 1'b0, 1'b0, V_DEF | BUSY);
        idle("mdr2_after", V_DEF);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined MIPS core. It merges four hazard sources into per-stage write-enable and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
- data-memory wait handshake
- multi-cycle mult/div occupancy of EX
- taken-branch flush
- load-use detection

It replaces the standalone combinational load-use detector, and adds a registered FSM and latency counter for the mult/div unit.

Parameters:
MD_LAT, 4, total EX-stage cycles of a mult/div instruction; legal range 1..16.
CNT_W, 4, width of the mult/div countdown counter; must satisfy 2^CNT_W > MD_LAT.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rt  in  5  destination register of the load in EX
if_id_rs  in  5  rs of the instruction in ID
if_id_rt  in  5  rt of the instruction in ID
if_id_uses_rt  in  1  instruction in ID reads rt
ex_branch_taken  in  1  branch or jump in EX resolved taken
ex_md_start  in  1  instruction in EX is mult/div
dmem_req  in  1  MEM stage has a valid load/store
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_bubble  out  1  load NOP into ID/EX
ex_mem_write  out  1  EX/MEM load enable
ex_mem_bubble  out  1  load NOP into EX/MEM
mem_wb_bubble  out  1  load NOP into MEM/WB
md_busy  out  1  mult/div occupies EX (state MD_BUSY)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low. Reset sets state to IDLE and md_cnt to 0.
- Output timing: all outputs are combinational from state, md_cnt and inputs.
- Output values with all inputs 0: enables 1, flush/bubble 0, md_busy 0.
- Internal signals:
  - mem_stall = dmem_req & ~dmem_ready
  - md_stall = (IDLE & ex_md_start & MD_LAT>1) | (MD_BUSY & md_cnt!=0)
  - load_use = id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt))
- Defaults: every enable = 1, every flush/bubble = 0. Rules are applied by strict priority; only the highest active rule acts.
  1. mem_stall: pc_write, if_id_write, id_ex_write and ex_mem_write = 0; mem_wb_bubble = 1.
  2. md_stall: pc_write, if_id_write and id_ex_write = 0; ex_mem_bubble = 1.
  3. ex_branch_taken: if_id_flush = 1, id_ex_bubble = 1; pc_write stays 1 for the redirect.
  4. load_use: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
- Flush deferral: a branch held in a frozen EX keeps ex_branch_taken high, so its flush is applied in the first unfrozen cycle.
- Branch vs load-use: branch wins, since the ID instruction is squashed.
- FSM states: IDLE, MD_BUSY.
  - IDLE -> MD_BUSY when ex_md_start & ~mem_stall & MD_LAT>1; load md_cnt = MD_LAT-2.
  - In MD_BUSY, md_cnt decrements every cycle (including mem_stall cycles) and saturates at 0.
  - MD_BUSY -> IDLE when md_cnt==0 & ~mem_stall. This is the release cycle: EX advances and ex_md_start is not re-accepted.
- Mult/div latency: EX occupancy is exactly MD_LAT cycles absent mem stalls. With MD_LAT=1 the FSM never leaves IDLE.
- ex_md_start and ex_branch_taken are never both high; their combined behaviour is undefined.
- Reset mid-operation returns to IDLE immediately with md_cnt=0.

Optional Feature:
Macro: STALL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_flush_cnt[31:0], both reset to 0 by rst_n.
  - perf_stall_cycles increments on each cycle with pc_write==0.
  - perf_flush_cnt increments on each cycle with if_id_flush==1.
  - Both counters wrap at 2^32.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
Shared package pipe_pkg holds:
- typedef md_state_t {IDLE, MD_BUSY}
- constant REG_ZERO = 5'd0
- the default MD_LAT value

Sub-module hazard_detect: combinational load_use term only, instantiated once. Priority logic and FSM stay in the top.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle. Repeat with id_ex_rt=0 -> no stall.
- Mult/div: MD_LAT=4, ex_md_start held 4 cycles -> ex_mem_bubble=1 and pc_write=0 in cycles 1-3, released in cycle 4. md_busy high in cycles 2-4.
- Memory wait during mult/div: dmem_req=1 with dmem_ready=0 for 5 cycles starting in cycle 2 of a mult/div -> ex_mem_write=0 and mem_wb_bubble=1 for those 5 cycles. MD_BUSY releases on the first cycle with dmem_ready=1.
- Branch vs load-use: ex_branch_taken=1 with load_use true -> if_id_flush=1, id_ex_bubble=1, pc_write=1.
- Frozen branch: branch while mem_stall for 2 cycles -> flush asserted only in cycle 3.
- Reset mid-MD_BUSY: rst_n low while md_cnt=2 -> md_busy=0 asynchronously; after release, a new ex_md_start restarts the full MD_LAT sequence. With STALL_PERF_EN, both perf counters read 0.
